// File: rtl/if_id_buffer.sv
// Fetch-to-decode instruction buffer: a small circular FIFO of {pc, pc_plus_4, instr}
// entries with valid/ready handshakes, NOP bubble when empty, branch flush and halt drain.
module if_id_buffer #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_fetch_valid,
  input  logic [XLEN-1:0]          i_fetch_pc,
  input  logic [XLEN-1:0]          i_fetch_pc_plus_4,
  input  logic [XLEN-1:0]          i_fetch_instr,
  output logic                     o_fetch_ready,
  output logic                     o_dec_valid,
  output logic [XLEN-1:0]          o_dec_pc,
  output logic [XLEN-1:0]          o_dec_pc_plus_4,
  output logic [XLEN-1:0]          o_dec_instr,
  input  logic                     i_dec_ready,
  input  logic                     i_flush,
  input  logic                     i_halt,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  entry_t          head;

  // Ready looks only at occupancy and control, never at i_dec_ready, so a full
  // buffer refuses a push even when decode pops in the same cycle.
  assign o_fetch_ready = (count < CW'(DEPTH)) & ~i_halt & ~i_flush;
  assign o_dec_valid   = (count != '0);
  assign push          = i_fetch_valid & o_fetch_ready;
  assign pop           = o_dec_valid & i_dec_ready;
  assign o_count       = count;
  assign head          = mem[rptr];

  always_comb begin
    o_dec_pc        = '0;
    o_dec_pc_plus_4 = '0;
    o_dec_instr     = NOP_INSTR;
    if (o_dec_valid) begin
      o_dec_pc        = head.pc;
      o_dec_pc_plus_4 = head.pc_plus_4;
      o_dec_instr     = head.instr;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: storage is cleared on reset so decode never sees stale X data;
    // that is why the array shares the reset branch with the pointers.
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= '{pc: i_fetch_pc, pc_plus_4: i_fetch_pc_plus_4, instr: i_fetch_instr};
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
